// File: rtl/rv32_mem_responder_if.sv
// Request/response bus between an RV32 initiator and rv32_mem_responder.
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata, req_be   : store data and byte enables (bit n -> bits [8n+7:8n])
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata, rsp_err  : load data (0 for stores) and access error flag
// Modports: master = initiator side, slave = responder side.
interface rv32_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rv32_mem_responder.sv
// Single-outstanding word-addressed memory responder for an RV32 data port.
// A request is accepted in IDLE; stores commit and load data is captured on
// the acceptance edge, then the response is presented LATENCY+1 cycles later
// and held until rsp_ready.
// Parameters: DEPTH_WORDS (power of two, 2..65536), LATENCY (0..15).
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; storage is not reset
//   bus   : rv32_mem_responder_if.slave request/response bus
// Optional feature: define MEM_ACCESS_CHECK_EN to flag out-of-range and
// misaligned accesses with rsp_err (errored accesses never write storage).
// Without it rsp_err is 0 and addresses wrap modulo DEPTH_WORDS*4.
module rv32_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 1
) (
  input logic                  clk,
  input logic                  reset,
  rv32_mem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LatCnt = 4'(LATENCY);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          accept;
  logic          acc_err;

  assign idx    = bus.req_addr[AW+1:2];
  assign accept = (state_q == StIdle) && bus.req_valid;

  // Address bits outside the word index only matter to the access checker.
  logic unused_addr;
  assign unused_addr = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};

`ifdef MEM_ACCESS_CHECK_EN
  localparam logic [32:0] MemBytes = 33'(DEPTH_WORDS) * 33'd4;

  always_comb begin
    acc_err = 1'b0;
    if ({1'b0, bus.req_addr} >= MemBytes) begin
      acc_err = 1'b1;
    end
    if ((bus.req_be == 4'b1111) && (bus.req_addr[1:0] != 2'b00)) begin
      acc_err = 1'b1;
    end
    if (((bus.req_be == 4'b0011) || (bus.req_be == 4'b1100)) && bus.req_addr[0]) begin
      acc_err = 1'b1;
    end
  end
`else
  assign acc_err = 1'b0;
`endif

  // The WAIT phase always spans LATENCY+1 cycles (counter loaded with LATENCY,
  // RESP entered once it reads 0), giving an acceptance-to-valid delay of
  // LATENCY+1 edges, including LATENCY=0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          err_d   = acc_err;
          rdata_d = (bus.req_we || acc_err) ? 32'h0 : mem_q[idx];
          cnt_d   = LatCnt;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && accept && bus.req_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req_be[i]) begin
          mem_q[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_rv32_mem_responder.sv
module tb_rv32_mem_responder;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  rv32_mem_responder_if bus_a ();
  rv32_mem_responder_if bus_b ();

  rv32_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  rv32_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full transaction on bus_a; returns response data, error flag and the
  // number of edges from acceptance to rsp_valid.
  task automatic access_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err,
                          output int lat);
    int guard;
    @(negedge clk);
    bus_a.req_valid = 1'b1;
    bus_a.req_we    = we;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wdata;
    bus_a.req_be    = be;
    guard = 0;
    while (bus_a.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    rdata = 32'hx;
    err   = 1'bx;
    lat   = -1;
    if (guard >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: req_ready=%b required 1", bus_a.req_ready);
      bus_a.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus_a.req_valid = 1'b0;
    lat = 0;
    while (bus_a.rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1", bus_a.rsp_valid);
      return;
    end
    rdata = bus_a.rsp_rdata;
    err   = bus_a.rsp_err;
    @(negedge clk);
    bus_a.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus_a.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus_a.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_valid: got %b required 0", bus_a.rsp_valid);
    end
    n_checks++;
    if (bus_a.rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rsp_rdata: got %h required 0", bus_a.rsp_rdata);
    end
    n_checks++;
    if (bus_a.rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_err: got %b required 0", bus_a.rsp_err);
    end
    n_checks++;
    if (bus_b.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_valid_l0: got %b required 0", bus_b.rsp_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus_a.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b required 1", bus_a.req_ready);
    end
    n_checks++;
    if (bus_b.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready_l0: got %b required 1", bus_b.req_ready);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic        er;
    int          lat;
    access_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL store_latency: got %0d required 2", lat);
    end
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      n_fail++; $display("FAIL store_rsp: got rdata %h err %b required 0/0", rd, er);
    end
    access_a(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL load_latency: got %0d required 2", lat);
    end
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_data: got %h required deadbeef", rd);
    end
    n_checks++;
    if (er !== 1'b0) begin
      n_fail++; $display("FAIL load_err: got %b required 0", er);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    logic        er;
    int          lat;
    access_a(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    access_a(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    access_a(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    n_checks++;
    if (rd !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL lanes_0101: got %h required 11bb33dd", rd);
    end
    // be = 0 writes nothing; low address bits are ignored
    access_a(1'b1, 32'h21, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    access_a(1'b0, 32'h23, 32'h0, 4'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL lanes_be0: got %h required 11bb33dd", rd);
    end
    access_a(1'b1, 32'h22, 32'h55660000, 4'b1100, rd, er, lat);
    access_a(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    n_checks++;
    if (rd !== 32'h556633DD) begin
      n_fail++; $display("FAIL lanes_1100: got %h required 556633dd", rd);
    end
  endtask

  task automatic test_backpressure();
    int guard;
    int lat;
    @(negedge clk);
    bus_a.req_valid = 1'b1;
    bus_a.req_we    = 1'b0;
    bus_a.req_addr  = 32'h10;
    bus_a.req_be    = 4'hF;
    @(posedge clk);
    #1;
    // Next request presented and held while the first is outstanding
    bus_a.req_addr = 32'h20;
    guard = 0;
    while (bus_a.rsp_valid !== 1'b1 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus_a.rsp_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_valid[%0d]: got %b required 1", i, bus_a.rsp_valid);
      end
      n_checks++;
      if (bus_a.rsp_rdata !== 32'hDEADBEEF) begin
        n_fail++; $display("FAIL bp_rdata[%0d]: got %h required deadbeef", i, bus_a.rsp_rdata);
      end
      n_checks++;
      if (bus_a.req_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_req_ready[%0d]: got %b required 0", i, bus_a.req_ready);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus_a.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus_a.rsp_ready = 1'b0;
    n_checks++;
    if (bus_a.rsp_valid !== 1'b0 || bus_a.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_handshake: got valid %b ready %b required 0/1",
               bus_a.rsp_valid, bus_a.req_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_a.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_held_accept: got req_ready %b required 0", bus_a.req_ready);
    end
    bus_a.req_valid = 1'b0;
    lat = 0;
    while (bus_a.rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_checks++;
    if (lat !== 2 || bus_a.rsp_rdata !== 32'h556633DD) begin
      n_fail++;
      $display("FAIL bp_second: got lat %0d rdata %h required 2/556633dd", lat, bus_a.rsp_rdata);
    end
    @(negedge clk);
    bus_a.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus_a.rsp_ready = 1'b0;
  endtask

  task automatic test_early_ready();
    @(negedge clk);
    bus_a.rsp_ready = 1'b1;
    bus_a.req_valid = 1'b1;
    bus_a.req_we    = 1'b0;
    bus_a.req_addr  = 32'h10;
    bus_a.req_be    = 4'hF;
    @(posedge clk);
    #1 bus_a.req_valid = 1'b0;
    n_checks++;
    if (bus_a.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL early_wait1: got %b required 0", bus_a.rsp_valid);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_a.rsp_valid !== 1'b0 || bus_a.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL early_wait2: got valid %b ready %b required 0/0",
               bus_a.rsp_valid, bus_a.req_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_a.rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL early_resp: got %b required 1", bus_a.rsp_valid);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_a.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL early_done: got %b required 0", bus_a.rsp_valid);
    end
    bus_a.rsp_ready = 1'b0;
  endtask

  task automatic test_addr_check();
    logic [31:0] rd;
    logic        er;
    int          lat;
`ifdef MEM_ACCESS_CHECK_EN
    access_a(1'b1, 32'h12, 32'h12345678, 4'hF, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
      n_fail++; $display("FAIL chk_misalign: got err %b rdata %h lat %0d required 1/0/2", er, rd, lat);
    end
    access_a(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    n_checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++; $display("FAIL chk_unchanged: got %h err %b required deadbeef/0", rd, er);
    end
    access_a(1'b0, 32'h400, 32'h0, 4'hF, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL chk_range: got err %b rdata %h required 1/0", er, rd);
    end
    access_a(1'b0, 32'h11, 32'h0, 4'b0011, rd, er, lat);
    n_checks++;
    if (er !== 1'b1) begin
      n_fail++; $display("FAIL chk_half: got err %b required 1", er);
    end
`else
    access_a(1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, er, lat);
    access_a(1'b0, 32'h400, 32'h0, 4'hF, rd, er, lat);
    n_checks++;
    if (rd !== 32'h0BADF00D || er !== 1'b0) begin
      n_fail++; $display("FAIL wrap_0x400: got %h err %b required 0badf00d/0", rd, er);
    end
    access_a(1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat);
    n_checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++; $display("FAIL wrap_misalign: got %h err %b required deadbeef/0", rd, er);
    end
`endif
  endtask

  task automatic test_latency0();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus_b.req_valid = 1'b1;
      bus_b.req_we    = (k == 0);
      bus_b.req_addr  = 32'h14;
      bus_b.req_wdata = 32'hCAFEF00D;
      bus_b.req_be    = 4'hF;
      @(posedge clk);
      #1 bus_b.req_valid = 1'b0;
      n_checks++;
      if (bus_b.rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL l0_early[%0d]: got %b required 0", k, bus_b.rsp_valid);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (bus_b.rsp_valid !== 1'b1) begin
        n_fail++; $display("FAIL l0_valid[%0d]: got %b required 1", k, bus_b.rsp_valid);
      end
      n_checks++;
      if (bus_b.rsp_rdata !== ((k == 0) ? 32'h0 : 32'hCAFEF00D)) begin
        n_fail++; $display("FAIL l0_rdata[%0d]: got %h", k, bus_b.rsp_rdata);
      end
      @(negedge clk);
      bus_b.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus_b.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          seen;
    @(negedge clk);
    bus_a.req_valid = 1'b1;
    bus_a.req_we    = 1'b1;
    bus_a.req_addr  = 32'h30;
    bus_a.req_wdata = 32'h600DCAFE;
    bus_a.req_be    = 4'hF;
    @(posedge clk);
    #1 bus_a.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus_a.rsp_valid !== 1'b0 || bus_a.rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_during: got valid %b rdata %h required 0/0",
               bus_a.rsp_valid, bus_a.rsp_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus_a.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_ready: got %b required 1", bus_a.req_ready);
    end
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus_a.rsp_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL rmid_dropped: got a response required none");
    end
    access_a(1'b0, 32'h30, 32'h0, 4'hF, rd, er, lat);
    n_checks++;
    if (rd !== 32'h600DCAFE) begin
      n_fail++; $display("FAIL rmid_committed: got %h required 600dcafe", rd);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus_a.req_valid = 1'b0;
    bus_a.req_we    = 1'b0;
    bus_a.req_addr  = 32'h0;
    bus_a.req_wdata = 32'h0;
    bus_a.req_be    = 4'h0;
    bus_a.rsp_ready = 1'b0;
    bus_b.req_valid = 1'b0;
    bus_b.req_we    = 1'b0;
    bus_b.req_addr  = 32'h0;
    bus_b.req_wdata = 32'h0;
    bus_b.req_be    = 4'h0;
    bus_b.rsp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_backpressure();
    test_early_ready();
    test_addr_check();
    test_latency0();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
